// File: rtl/arb_pkg.sv
// arb_pkg: payload type and width helper shared by the round-robin arbiter blocks
package arb_pkg;

    typedef struct packed {
        int a;
    } user_int_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_payload_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder, first set request at or after ptr
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any
);

    localparam logic [W:0] NW = (W + 1)'(N);

    logic [W:0] s;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant = '0;
        s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (W + 1)'(k);
            s = (s >= NW) ? s - NW : s;
            grant = req[s[W-1:0]] ? s[W-1:0] : grant;
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_payload_arbiter.sv
// rr_payload_arbiter: round-robin arbitration of NUM_REQ payload channels into one
// registered output slot, with per-requester saturating grant counters
module rr_payload_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    parameter int SRC_W   = clog2_min1(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  var bit [NUM_REQ-1:0] req_valid,
    input  var user_int_t        req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output user_int_t            out_data,
    output logic [SRC_W-1:0]     out_src,
    input  logic                 out_ready,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     grant_cnt [NUM_REQ]
);

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant;
    logic             any;
    logic             load_en;
    logic             hs;

    rr_pick #(.N(NUM_REQ), .W(SRC_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any)
    );

    assign load_en   = !out_valid || out_ready;
    assign hs        = rst_n && load_en && any;
    assign req_ready = hs ? (NUM_REQ'(1) << grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (hs) begin
            out_valid <= 1'b1;
            out_data  <= req_data[grant];
            out_src   <= grant;
            rr_ptr    <= (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear takes priority over a coincident grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                grant_cnt[i] <= clr_cnt ? '0 :
                                (hs && grant == SRC_W'(i) && grant_cnt[i] != '1) ? grant_cnt[i] + 1'b1 :
                                grant_cnt[i];
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> $stable(out_data) && $stable(out_src));
    a_known:  assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req_ready));

endmodule

// File: tb/tb_rr_payload_arbiter.sv
// tb_rr_payload_arbiter: directed vectors for 4- and 3-requester arbiter instances
module tb_rr_payload_arbiter;
    import arb_pkg::*;

    logic clk;
    int   n_vec = 0;
    int   n_err = 0;

    logic       rst4, ordy4, clr4, ov4;
    bit [3:0]   rv4;
    user_int_t  d4 [4];
    logic [3:0] rr4;
    user_int_t  od4;
    logic [1:0] os4;
    logic [7:0] gc4 [4];

    logic       rst3, ordy3, clr3, ov3;
    bit [2:0]   rv3;
    user_int_t  d3 [3];
    logic [2:0] rr3;
    user_int_t  od3;
    logic [1:0] os3;
    logic [7:0] gc3 [3];

    rr_payload_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst4), .req_valid(rv4), .req_data(d4), .req_ready(rr4),
        .out_valid(ov4), .out_data(od4), .out_src(os4), .out_ready(ordy4),
        .clr_cnt(clr4), .grant_cnt(gc4)
    );

    rr_payload_arbiter #(.NUM_REQ(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst3), .req_valid(rv3), .req_data(d3), .req_ready(rr3),
        .out_valid(ov3), .out_data(od3), .out_src(os3), .out_ready(ordy3),
        .clr_cnt(clr3), .grant_cnt(gc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst4 = 1'b0; rst3 = 1'b0;
        rv4 = 4'hF; rv3 = '0;
        ordy4 = 1'b0; ordy3 = 1'b1;
        clr4 = 1'b0; clr3 = 1'b0;
        for (int i = 0; i < 4; i++) d4[i].a = 10 + i;
        for (int i = 0; i < 3; i++) d3[i].a = 20 + i;
        tick(); tick();
        check("rst_ov", ov4, 0);
        check("rst_ready", rr4, 0);
        check("rst_data", od4.a, 0);
        for (int i = 0; i < 4; i++) check("rst_cnt", gc4[i], 0);

        // stall with a single requester
        rv4 = 4'b0100;
        d4[2].a = 32'h5A5A;
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        check("stall_ready_pre", rr4, 4'b0100);
        tick();
        check("stall_ov", ov4, 1);
        check("stall_src", os4, 2);
        check("stall_data", od4.a, 32'h5A5A);
        d4[2].a = 32'h1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ready", rr4, 0);
            tick();
            check("stall_hold", od4.a, 32'h5A5A);
            check("stall_cnt", gc4[2], 1);
        end

        // asynchronous reset while stalled
        #2;
        rst4 = 1'b0;
        #1;
        check("arst_ov", ov4, 0);
        check("arst_data", od4.a, 0);
        check("arst_cnt", gc4[2], 0);
        tick();
        rv4 = 4'hF;
        for (int i = 0; i < 4; i++) d4[i].a = 10 + i;
        ordy4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b1;

        // full rotation
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rot_src", os4, k % 4);
            check("rot_data", od4.a, 10 + k % 4);
        end
        for (int i = 0; i < 4; i++) check("rot_cnt", gc4[i], 2);

        // drain without refill
        rv4 = '0;
        tick();
        check("drain_ov", ov4, 0);
        check("drain_data", od4.a, 13);
        check("drain_src", os4, 3);

        // clear, saturate, clear against a grant
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        for (int i = 0; i < 4; i++) check("clr_cnt", gc4[i], 0);
        rv4 = 4'b0010;
        for (int k = 1; k <= 257; k++) begin
            tick();
            if (k >= 254) check("sat_cnt", gc4[1], k >= 255 ? 255 : 254);
        end
        check("sat_other", gc4[0], 0);
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        check("clr_win", gc4[1], 0);
        check("clr_src", os4, 1);
        tick();
        check("post_clr", gc4[1], 1);
        rv4 = '0;

        // three requesters, pointer wrap
        @(negedge clk);
        rst3 = 1'b1;
        rv3 = 3'b010;
        tick();
        check("n3_first", os3, 1);
        rv3 = 3'b101;
        #1;
        check("n3_ready", rr3, 3'b100);
        tick();
        check("n3_g2", os3, 2);
        check("n3_d2", od3.a, 22);
        tick();
        check("n3_wrap", os3, 0);
        check("n3_d0", od3.a, 20);
        tick();
        check("n3_next", os3, 2);
        rv3 = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_payload_arbiter.md
Name: rr_payload_arbiter

Overview:
- Round-robin arbiter that shares one downstream consumer between NUM_REQ requesters.
- Each requester offers a user_int_t payload on a valid/ready channel.
- The winner's payload is captured into a single registered output slot, tagged with its source index, and held until the consumer accepts it.
- Sits in front of any single-port consumer of user_int_t data and sequences access to it.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16, need not be a power of two.
- CNT_W, 8, width of each per-requester saturating grant counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester payload-valid; 2-state, declared input var bit.
- req_data  input  NUM_REQ x user_int_t  unpacked array of payloads; declared input var.
- req_ready  output  NUM_REQ  per-requester accept; combinational, one-hot or zero.
- out_valid  output  1  output slot holds a payload.
- out_data  output  user_int_t  registered payload.
- out_src  output  SRC_W  index of the requester that supplied out_data; SRC_W = $clog2(NUM_REQ).
- out_ready  input  1  consumer accepts out_data this cycle.
- clr_cnt  input  1  synchronous clear of all grant counters.
- grant_cnt  output  NUM_REQ x CNT_W  per-requester accepted-grant counters.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0, grant_cnt all 0.
  - req_ready is all 0 while in reset.
  - Any in-flight payload is discarded, not replayed.
- Load enable:
  - load_en = !out_valid || out_ready.
  - The slot accepts a new payload when it is empty or being drained in the same cycle.
- Arbitration (combinational, evaluated every cycle):
  - Search for the first i with req_valid[i]=1, starting at rr_ptr and wrapping NUM_REQ-1 -> 0.
  - req_ready[grant] = load_en && any req_valid; all other req_ready bits are 0.
  - req_ready must not depend on out_data; it may depend on out_ready (comb path allowed).
- Handshake, on the edge with req_valid[g] && req_ready[g]:
  - out_data <= req_data[g], out_src <= g, out_valid <= 1.
  - rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1. Explicit wrap; no modulo by a non-power-of-two.
  - grant_cnt[g] increments, saturating at 2^CNT_W-1.
- Drain without refill (out_valid && out_ready, no req_valid): out_valid <= 0; out_data and out_src hold their last value.
- Stall (out_valid && !out_ready): out_valid, out_data and out_src stay stable; all req_ready = 0; rr_ptr holds.
- Throughput and latency:
  - One payload per cycle when out_ready stays high.
  - Latency is 1 cycle from request handshake to out_valid.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... Every requester wins at least once in any NUM_REQ consecutive grants.
- Requester rules (upstream obligations, checked by bench assertions):
  - A requester may drop req_valid without a handshake.
  - The arbiter keeps no grant lock across cycles.
- Counter clear:
  - clr_cnt=1 zeroes all counters on the next edge.
  - If clr_cnt and a grant coincide, clear wins and the counter ends at 0.
- Assertions:
  - $onehot0(req_ready).
  - out_data and out_src stable while out_valid && !out_ready.
  - No X on req_ready after reset release.

Decomposition:
- Shared package arb_pkg:
  - user_int_t (packed struct, field int a).
  - function clog2_min1 (returns at least 1 for SRC_W).
- One sub-module rr_pick: a pure combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, any.
  - Reused by future schedulers.
- Top-level file holds the output slot, rr_ptr and counters.

Test Plan:
- Reset mid-stall: out_valid=1 with out_ready=0, assert rst_n=0 -> out_valid=0, out_data.a=0, grant_cnt=0 immediately (asynchronous); after release, first grant goes to requester 0.
- All four valid, payloads a=10,11,12,13, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles; out_data.a matches; each grant_cnt=2 after 8 cycles.
- Only req 2 valid with a=0x5A5A, out_ready held 0 for 3 cycles -> req_ready=0 during stall; out_data.a stays 0x5A5A; one handshake only; grant_cnt[2]=1.
- NUM_REQ=3, rr_ptr at 2, req 0 and 2 valid -> grant 2, then rr_ptr wraps to 0; next grant 0.
- grant_cnt preloaded to 254 (CNT_W=8), 3 grants to req 1 -> counter 255, holds; clr_cnt pulsed together with a grant -> counter 0.
- Drain with no requests: out_valid=1, out_ready=1, all req_valid=0 -> out_valid=0 next cycle; out_data unchanged.
